// File: rtl/imem_loader_arb_if.sv
// Bundles the fetch, loader and instruction-memory signals of imem_loader_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding
// fetch stage, loader source and memory instance.
interface imem_loader_arb_if #(
  parameter int unsigned AWIDTH        = 32,
  parameter int unsigned DWIDTH        = 32,
  parameter int unsigned LOG2_MEM_SIZE = 8
);

  localparam int unsigned LWIDTH = LOG2_MEM_SIZE + 2;

  // fetch stage
  logic              i_fetch_rq;
  logic [AWIDTH-1:0] i_fetch_pc;
  logic [DWIDTH-1:0] o_fetch_data;
  logic              o_fetch_valid;
  logic              o_stall;

  // loader stream
  logic              i_ld_start;
  logic [AWIDTH-1:0] i_ld_base;
  logic [LWIDTH-1:0] i_ld_len;
  logic              i_ld_valid;
  logic [DWIDTH-1:0] i_ld_data;
  logic              o_ld_ready;
  logic              o_ld_busy;
  logic              o_ld_done;
  logic              o_ld_err;

  // instruction memory port
  logic              o_mem_rq;
  logic              o_mem_rnw;
  logic [AWIDTH-1:0] o_mem_addr;
  logic [DWIDTH-1:0] o_mem_wdata;
  logic [DWIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_fetch_rq, i_fetch_pc,
    input  i_ld_start, i_ld_base, i_ld_len, i_ld_valid, i_ld_data,
    input  i_mem_rdata,
    output o_fetch_data, o_fetch_valid, o_stall,
    output o_ld_ready, o_ld_busy, o_ld_done, o_ld_err,
    output o_mem_rq, o_mem_rnw, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_fetch_rq, i_fetch_pc,
    output i_ld_start, i_ld_base, i_ld_len, i_ld_valid, i_ld_data,
    output i_mem_rdata,
    input  o_fetch_data, o_fetch_valid, o_stall,
    input  o_ld_ready, o_ld_busy, o_ld_done, o_ld_err,
    input  o_mem_rq, o_mem_rnw, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/imem_loader_arb.sv
// Instruction-memory port arbiter: fetch reads pass straight through while idle;
// an accepted load start hands the port to the loader, which writes a burst of
// words at consecutive addresses while fetch is stalled.
module imem_loader_arb #(
  parameter int unsigned AWIDTH        = 32,
  parameter int unsigned DWIDTH        = 32,
  parameter int unsigned LOG2_MEM_SIZE = 8
) (
  input logic              i_clk,
  input logic              i_reset,
  imem_loader_arb_if.slave bus
);

  localparam int unsigned LWIDTH    = LOG2_MEM_SIZE + 2;
  localparam int unsigned MEM_WORDS = 2 << LOG2_MEM_SIZE;
  // one spare bit so base word index + length cannot overflow the range check
  localparam int unsigned CWIDTH    = AWIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] addr_q;
  logic [LWIDTH-1:0] remaining_q;
  logic              ld_ready_q;
  logic              ld_busy_q;
  logic              ld_done_q;
  logic              ld_err_q;

  logic [CWIDTH-1:0] end_word_c;
  logic              start_bad_c;
  logic              last_word_c;

  // Range/alignment check on the start request: the burst must end at or below MEM_WORDS.
  always_comb begin
    end_word_c  = CWIDTH'(bus.i_ld_base >> 2) + CWIDTH'(bus.i_ld_len);
    start_bad_c = (bus.i_ld_base[1:0] != 2'b00) || (end_word_c > CWIDTH'(MEM_WORDS));
    last_word_c = (remaining_q == LWIDTH'(1));
  end

  // Load sequencer: state, burst address/count and registered loader status flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      ld_ready_q  <= 1'b0;
      ld_busy_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      ld_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_ld_start) begin
            if (start_bad_c) begin
              ld_err_q <= 1'b1;
            end else if (bus.i_ld_len == '0) begin
              state     <= S_DONE;
              ld_busy_q <= 1'b1;
              ld_done_q <= 1'b1;
            end else begin
              state       <= S_LOAD;
              addr_q      <= bus.i_ld_base;
              remaining_q <= bus.i_ld_len;
              ld_busy_q   <= 1'b1;
              ld_ready_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // further start pulses are ignored here; only the handshake advances the burst
          if (bus.i_ld_valid) begin
            addr_q      <= addr_q + AWIDTH'(4);
            remaining_q <= remaining_q - LWIDTH'(1);
            if (last_word_c) begin
              state      <= S_DONE;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          ld_done_q <= 1'b0;
          ld_busy_q <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          ld_ready_q <= 1'b0;
          ld_busy_q  <= 1'b0;
          ld_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Port steering: fetch passes through combinationally in IDLE, loader writes in LOAD.
  always_comb begin
    bus.o_mem_rq      = 1'b0;
    bus.o_mem_rnw     = 1'b1;
    bus.o_mem_addr    = '0;
    bus.o_mem_wdata   = '0;
    bus.o_fetch_valid = 1'b0;
    bus.o_stall       = 1'b0;
    case (state)
      S_IDLE: begin
        bus.o_mem_rq      = bus.i_fetch_rq;
        bus.o_mem_addr    = bus.i_fetch_pc;
        bus.o_fetch_valid = bus.i_fetch_rq;
      end
      S_LOAD: begin
        bus.o_mem_rq    = bus.i_ld_valid;
        bus.o_mem_rnw   = 1'b0;
        bus.o_mem_addr  = addr_q;
        bus.o_mem_wdata = bus.i_ld_data;
        bus.o_stall     = bus.i_fetch_rq;
      end
      S_DONE: begin
        bus.o_stall = bus.i_fetch_rq;
      end
      default: begin
        bus.o_stall = bus.i_fetch_rq;
      end
    endcase
  end

  // Fetch data is the memory read data unconditionally; validity is qualified separately.
  always_comb begin
    bus.o_fetch_data = bus.i_mem_rdata;
  end

  // Registered loader status out to the interface.
  always_comb begin
    bus.o_ld_ready = ld_ready_q;
    bus.o_ld_busy  = ld_busy_q;
    bus.o_ld_done  = ld_done_q;
    bus.o_ld_err   = ld_err_q;
  end

endmodule

// File: tb/tb_imem_loader_arb.sv
// Bench for imem_loader_arb: word-addressed memory model behind the port, a
// table of idle fetch vectors, and scripted load / reject / reset sequences
// whose expected memory writes go through a scoreboard queue.
module tb_imem_loader_arb;

  logic clk;
  logic rst;
  logic mem_init;

  imem_loader_arb_if #(.AWIDTH(32), .DWIDTH(32), .LOG2_MEM_SIZE(8)) bus ();

  imem_loader_arb #(.AWIDTH(32), .DWIDTH(32), .LOG2_MEM_SIZE(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks;
  int failures;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        rq;
    logic [31:0] pc;
    logic        exp_rq;
    logic        exp_valid;
    logic [31:0] exp_data;
  } fvec_t;
  fvec_t vecs[6];

  logic [31:0] mem [0:511];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, write on the clock edge
  assign bus.i_mem_rdata = mem[bus.o_mem_addr[10:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else if (bus.o_mem_rq && !bus.o_mem_rnw) begin
      mem[bus.o_mem_addr[10:2]] <= bus.o_mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // write monitor: every memory write must match the next scoreboard entry
  wr_t mon_e;
  always @(negedge clk) begin
    #4;
    if (!rst && !mem_init && bus.o_mem_rq && !bus.o_mem_rnw) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h required=no_write at %0t",
                 bus.o_mem_addr, bus.o_mem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.o_mem_addr, mon_e.addr);
        check("wr_data", bus.o_mem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic fetch_check(input string name, input logic [31:0] pc, input logic [31:0] exp);
    @(negedge clk);
    bus.i_fetch_rq = 1'b1;
    bus.i_fetch_pc = pc;
    #1;
    check({name, "_valid"}, 32'(bus.o_fetch_valid), 32'd1);
    check({name, "_stall"}, 32'(bus.o_stall), 32'd0);
    check({name, "_data"}, bus.o_fetch_data, exp);
  endtask

  // full load burst; optional idle gap before each word and optional restart pulses
  task automatic run_load(input logic [31:0] base, input int len, input logic [31:0] d0,
                          input bit gap, input bit restart);
    logic [31:0] a;
    wr_t w;
    a = base;
    @(negedge clk);
    bus.i_ld_start = 1'b1;
    bus.i_ld_base  = base;
    bus.i_ld_len   = 10'(len);
    @(negedge clk);
    bus.i_ld_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (gap) begin
        bus.i_ld_valid = 1'b0;
        #1;
        check("gap_rq", 32'(bus.o_mem_rq), 32'd0);
        check("gap_ready", 32'(bus.o_ld_ready), 32'd1);
        check("gap_stall", 32'(bus.o_stall), 32'(bus.i_fetch_rq));
        @(negedge clk);
      end
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = d0 + 32'(k);
      w.addr = a;
      w.data = d0 + 32'(k);
      exp_q.push_back(w);
      a = a + 32'd4;
      if (restart && k == 0) begin
        bus.i_ld_start = 1'b1;
        bus.i_ld_base  = 32'h0;
        bus.i_ld_len   = 10'd5;
      end
      if (restart && k == 1) begin
        bus.i_ld_start = 1'b1;
        bus.i_ld_base  = 32'h2;
        bus.i_ld_len   = 10'd5;
      end
      #1;
      check("ld_ready", 32'(bus.o_ld_ready), 32'd1);
      check("ld_busy", 32'(bus.o_ld_busy), 32'd1);
      check("ld_mem_rq", 32'(bus.o_mem_rq), 32'd1);
      check("ld_mem_rnw", 32'(bus.o_mem_rnw), 32'd0);
      check("ld_fetch_valid", 32'(bus.o_fetch_valid), 32'd0);
      check("ld_stall", 32'(bus.o_stall), 32'(bus.i_fetch_rq));
      check("ld_err", 32'(bus.o_ld_err), 32'd0);
      check("ld_done_early", 32'(bus.o_ld_done), 32'd0);
      @(negedge clk);
      bus.i_ld_start = 1'b0;
      bus.i_ld_valid = 1'b0;
    end
    #1;
    check("done_pulse", 32'(bus.o_ld_done), 32'd1);
    check("done_busy", 32'(bus.o_ld_busy), 32'd1);
    check("done_ready", 32'(bus.o_ld_ready), 32'd0);
    check("done_mem_rq", 32'(bus.o_mem_rq), 32'd0);
    check("done_stall", 32'(bus.o_stall), 32'(bus.i_fetch_rq));
    check("done_fetch_valid", 32'(bus.o_fetch_valid), 32'd0);
    check("done_err", 32'(bus.o_ld_err), 32'd0);
    @(negedge clk);
    #1;
    check("post_done", 32'(bus.o_ld_done), 32'd0);
    check("post_busy", 32'(bus.o_ld_busy), 32'd0);
  endtask

  task automatic start_reject(input string name, input logic [31:0] base, input int len);
    @(negedge clk);
    bus.i_ld_start = 1'b1;
    bus.i_ld_base  = base;
    bus.i_ld_len   = 10'(len);
    #1;
    check({name, "_err_same"}, 32'(bus.o_ld_err), 32'd0);
    @(negedge clk);
    bus.i_ld_start = 1'b0;
    #1;
    check({name, "_err"}, 32'(bus.o_ld_err), 32'd1);
    check({name, "_busy"}, 32'(bus.o_ld_busy), 32'd0);
    check({name, "_ready"}, 32'(bus.o_ld_ready), 32'd0);
    check({name, "_fetch_valid"}, 32'(bus.o_fetch_valid), 32'd1);
    @(negedge clk);
    #1;
    check({name, "_err_off"}, 32'(bus.o_ld_err), 32'd0);
    check({name, "_busy_off"}, 32'(bus.o_ld_busy), 32'd0);
  endtask

  initial begin
    wr_t w;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    mem_init = 1'b1;
    bus.i_fetch_rq = 1'b0;
    bus.i_fetch_pc = '0;
    bus.i_ld_start = 1'b0;
    bus.i_ld_base  = '0;
    bus.i_ld_len   = '0;
    bus.i_ld_valid = 1'b0;
    bus.i_ld_data  = '0;

    vecs[0] = '{1'b1, 32'h000, 1'b1, 1'b1, 32'hC0DE0000};
    vecs[1] = '{1'b1, 32'h7FC, 1'b1, 1'b1, 32'hC0DE01FF};
    vecs[2] = '{1'b0, 32'h010, 1'b0, 1'b0, 32'hC0DE0004};
    vecs[3] = '{1'b1, 32'h400, 1'b1, 1'b1, 32'hC0DE0100};
    vecs[4] = '{1'b1, 32'h104, 1'b1, 1'b1, 32'hC0DE0041};
    vecs[5] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'hC0DE0000};

    repeat (3) @(negedge clk);
    rst      = 1'b0;
    mem_init = 1'b0;

    // reset state, idle inputs
    #1;
    check("rst_mem_rq", 32'(bus.o_mem_rq), 32'd0);
    check("rst_mem_rnw", 32'(bus.o_mem_rnw), 32'd1);
    check("rst_mem_addr", bus.o_mem_addr, 32'h0);
    check("rst_mem_wdata", bus.o_mem_wdata, 32'h0);
    check("rst_fetch_valid", 32'(bus.o_fetch_valid), 32'd0);
    check("rst_stall", 32'(bus.o_stall), 32'd0);

    // reset state with fetch of 0x8
    @(negedge clk);
    bus.i_fetch_rq = 1'b1;
    bus.i_fetch_pc = 32'h8;
    #1;
    check("rst_fetch_addr", bus.o_mem_addr, 32'h8);
    check("rst_fetch_rnw", 32'(bus.o_mem_rnw), 32'd1);
    check("rst_fetch_valid1", 32'(bus.o_fetch_valid), 32'd1);
    check("rst_fetch_stall", 32'(bus.o_stall), 32'd0);
    check("rst_fetch_data", bus.o_fetch_data, 32'hC0DE0002);
    check("rst_ld_ready", 32'(bus.o_ld_ready), 32'd0);
    check("rst_ld_busy", 32'(bus.o_ld_busy), 32'd0);
    check("rst_ld_done", 32'(bus.o_ld_done), 32'd0);
    check("rst_ld_err", 32'(bus.o_ld_err), 32'd0);

    // idle fetch vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.i_fetch_rq = vecs[i].rq;
      bus.i_fetch_pc = vecs[i].pc;
      #1;
      check("vec_mem_rq", 32'(bus.o_mem_rq), 32'(vecs[i].exp_rq));
      check("vec_mem_addr", bus.o_mem_addr, vecs[i].pc);
      check("vec_mem_rnw", 32'(bus.o_mem_rnw), 32'd1);
      check("vec_fetch_valid", 32'(bus.o_fetch_valid), 32'(vecs[i].exp_valid));
      check("vec_stall", 32'(bus.o_stall), 32'd0);
      check("vec_fetch_data", bus.o_fetch_data, vecs[i].exp_data);
    end

    // back-to-back load of 3 words, fetch held requesting
    bus.i_fetch_rq = 1'b1;
    bus.i_fetch_pc = 32'h104;
    run_load(32'h100, 3, 32'hA, 1'b0, 1'b0);
    fetch_check("after_b2b_104", 32'h104, 32'hB);
    fetch_check("after_b2b_100", 32'h100, 32'hA);

    // same load with gaps, different data to tell it apart
    run_load(32'h100, 3, 32'h1A, 1'b1, 1'b0);
    fetch_check("after_gap_108", 32'h108, 32'h1C);
    fetch_check("after_gap_10c", 32'h10C, 32'hC0DE0043);

    // rejected starts
    start_reject("misaligned", 32'h102, 2);
    start_reject("overrange", 32'h7FC, 2);
    fetch_check("after_rej_7fc", 32'h7FC, 32'hC0DE01FF);

    // exactly-fitting load at the top of memory is accepted
    run_load(32'h7F8, 2, 32'h55, 1'b0, 1'b0);
    fetch_check("top_7fc", 32'h7FC, 32'h56);

    // zero-length load: done next cycle, no writes
    @(negedge clk);
    bus.i_ld_start = 1'b1;
    bus.i_ld_base  = 32'h200;
    bus.i_ld_len   = 10'd0;
    @(negedge clk);
    bus.i_ld_start = 1'b0;
    #1;
    check("len0_done", 32'(bus.o_ld_done), 32'd1);
    check("len0_busy", 32'(bus.o_ld_busy), 32'd1);
    check("len0_err", 32'(bus.o_ld_err), 32'd0);
    check("len0_stall", 32'(bus.o_stall), 32'd1);
    @(negedge clk);
    #1;
    check("len0_done_off", 32'(bus.o_ld_done), 32'd0);
    check("len0_busy_off", 32'(bus.o_ld_busy), 32'd0);
    fetch_check("len0_200", 32'h200, 32'hC0DE0080);

    // restart pulses during LOAD are ignored
    run_load(32'h180, 2, 32'h90, 1'b0, 1'b1);
    fetch_check("restart_184", 32'h184, 32'h91);
    fetch_check("restart_000", 32'h000, 32'hC0DE0000);

    // reset after 2 of 4 words
    @(negedge clk);
    bus.i_ld_start = 1'b1;
    bus.i_ld_base  = 32'h40;
    bus.i_ld_len   = 10'd4;
    @(negedge clk);
    bus.i_ld_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = 32'h70 + 32'(k);
      w.addr = 32'h40 + 32'(4 * k);
      w.data = 32'h70 + 32'(k);
      exp_q.push_back(w);
      @(negedge clk);
      bus.i_ld_valid = 1'b0;
    end
    #1;
    check("mid_busy", 32'(bus.o_ld_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.o_ld_busy), 32'd0);
    check("mid_rst_done", 32'(bus.o_ld_done), 32'd0);
    check("mid_rst_ready", 32'(bus.o_ld_ready), 32'd0);
    check("mid_rst_stall", 32'(bus.o_stall), 32'd0);
    check("mid_rst_fetch_valid", 32'(bus.o_fetch_valid), 32'd1);
    @(negedge clk);
    #1;
    check("mid_rst_done2", 32'(bus.o_ld_done), 32'd0);
    fetch_check("mid_40", 32'h40, 32'h70);
    fetch_check("mid_44", 32'h44, 32'h71);
    fetch_check("mid_48", 32'h48, 32'hC0DE0012);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
